booth_mul_pipe: RTL and testbench
=================================

BOOTH_MUL_PIPE -- requirements
Module: booth_mul_pipe

Interface
REQ-001 SHALL have parameter BITS, default 8, giving the signed operand width (even, >= 4).
REQ-002 SHALL have parameter ACC_BITS, default 2*BITS+8, giving the accumulator width (used only with BOOTH_MUL_PIPE_ACC_EN).
REQ-003 SHALL define OUT_W as ACC_BITS when BOOTH_MUL_PIPE_ACC_EN is defined, else 2*BITS.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operand pair present.
REQ-008 in_ready  output  1  block accepts the operand pair this cycle.
REQ-009 a  input  BITS  signed multiplicand.
REQ-010 b  input  BITS  signed multiplier (Booth-encoded).
REQ-011 acc_clear  input  1  restart accumulation with this pair (ignored without the macro).
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_data  output  OUT_W  signed product, or running sum with the macro.

Function
REQ-015 SHALL accept an input when in_valid and in_ready are both 1 on a rising edge, and deliver an output when out_valid and out_ready are both 1.
REQ-016 SHALL use radix-4 Booth encoding: BITS/2 partial products from the triplets {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0, each selecting 0, +-a or +-2a.
REQ-017 SHALL handle sign extension with the inverted-sign/constant-one scheme, and add negation bits as carry-ins, with no full-width sign extension per row.
REQ-018 SHALL pipeline as follows: S1 registers the partial products and neg bits; S2 registers the carry-save reduction of the rows to two vectors; S3 registers the final carry-propagate sum.
REQ-019 SHALL have a latency of exactly 3 cycles from the accept edge to out_valid=1 when there is no backpressure.
REQ-020 SHALL sustain a throughput of 1 result per cycle while out_ready=1.
REQ-021 SHALL let each stage hold its contents when the downstream stage is full and not advancing.
REQ-022 SHALL drive in_ready = !S1_valid | S1 advancing, where a stage advances when the next stage is empty or advancing; the combinational path from out_ready to in_ready is permitted.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL never drop or duplicate a result, including when the pipeline is full, out_ready toggles every cycle, and an input is accepted in the same cycle an output leaves.
REQ-025 SHALL compute the product as the exact two's-complement value over 2*BITS bits; the corner case a=b=-2^(BITS-1) yields +2^(2*BITS-2).
REQ-026 SHALL not change any output or state when in_valid=0 and the pipeline is empty.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear all stage valid bits, set out_valid=0 and out_data=0, and clear the accumulator to 0.
REQ-028 SHALL hold in_ready=1 during reset; no input is accepted while rst_n=0.
REQ-029 SHALL discard in-flight operands when reset asserts mid-operation; the first result after reset comes only from an input accepted after rst_n rises.

Configuration
REQ-030 SHALL, when macro BOOTH_MUL_PIPE_ACC_EN is defined, compile in a signed ACC_BITS accumulator updated in S3.
REQ-031 SHALL, with the macro defined, pipeline acc_clear alongside its operands.
REQ-032 SHALL, with the macro defined, on each S3 load set acc = sext(product) if the tagged clear is 1, else acc + sext(product), wrapping modulo 2^ACC_BITS.
REQ-033 SHALL, with the macro defined, drive out_data = new acc value.
REQ-034 SHALL, without the macro, have no accumulator, ignore acc_clear, and drive out_data = product.

Verification
REQ-035 BITS=8, no macro, a=-128, b=-128 -> out_data=0x4000 exactly 3 cycles after accept.
REQ-036 BITS=8, a=127, b=-128, then a=-1, b=1 back-to-back with out_ready=1 -> 0xC080 then 0xFFFF on consecutive cycles.
REQ-037 Stream of 16 random pairs with out_ready held 0 for 5 cycles mid-stream -> in_ready=0 once 3 results are queued; all 16 results delivered in order, none lost or duplicated.
REQ-038 rst_n pulsed low with 2 results in flight -> out_valid=0 immediately; no stale result appears afterwards.
REQ-039 Macro defined, BITS=8: pairs (3,4, clear=1), (5,-6), (-128,-128) -> out_data=12, -18, 16366.
REQ-040 Exhaustive BITS=4 sweep (256 pairs) against a behavioral a*b model -> zero mismatches.

Source files
------------

// File: rtl/booth_mul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : booth_mul_pipe                                             |
// | Description : Three-stage pipelined radix-4 Booth signed multiplier with |
// |               valid/ready handshakes on both sides and an optional       |
// |               running-sum accumulator.                                   |
// |                 S1 : Booth-selected partial-product rows + negate bits   |
// |                 S2 : carry-save reduction of all rows to sum/carry       |
// |                 S3 : carry-propagate add (and accumulate when enabled)   |
// | Option      : define BOOTH_MUL_PIPE_ACC_EN to build the accumulator.     |
// |               out_data is then ACC_BITS wide and carries the running     |
// |               sum; acc_clear travels with its operands and restarts the  |
// |               sum. Without it, out_data is the 2*BITS-bit product and    |
// |               acc_clear is ignored.                                      |
// | Ports       : clk, rst_n (async, active low)                             |
// |               in_valid / in_ready / a / b / acc_clear   (operand side)   |
// |               out_valid / out_ready / out_data          (result side)    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module booth_mul_pipe #(
  parameter int BITS     = 8,
  parameter int ACC_BITS = 2*BITS+8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     a,
  input  logic [BITS-1:0]     b,
  input  logic                acc_clear,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef BOOTH_MUL_PIPE_ACC_EN
  output logic [ACC_BITS-1:0] out_data
`else
  output logic [2*BITS-1:0]   out_data
`endif
);

`ifdef BOOTH_MUL_PIPE_ACC_EN
  localparam int OUT_W = ACC_BITS;
`else
  localparam int OUT_W = 2*BITS;
`endif
  localparam int C_ROWS = BITS/2;     // one row per Booth digit
  localparam int C_RW   = BITS+1;     // row width: +-2a needs one extra bit
  localparam int C_PW   = 2*BITS;     // product width

  // Each row is stored with its sign bit inverted, which turns it into an
  // unsigned number that is 2^(BITS+2i) too large. All those offsets are
  // folded into one constant added once during reduction.
  function automatic logic [C_PW-1:0] corr_const();
    logic [C_PW-1:0] s;
    s = '0;
    for (int i = 0; i < C_ROWS; i++) begin
      s = s + (C_PW'(1) << (BITS + 2*i));
    end
    return ~s + 1'b1;
  endfunction
  localparam logic [C_PW-1:0] C_CORR = corr_const();

  // ---------------------------------------------------------------- control
  logic r_v1, r_v2, r_v3;
  logic w_rdy1, w_rdy2, w_rdy3;
  logic w_ld1, w_ld2, w_ld3;

  // A stage can take new data when it is empty or its content moves on.
  assign w_rdy3 = !r_v3 || out_ready;
  assign w_rdy2 = !r_v2 || w_rdy3;
  assign w_rdy1 = !r_v1 || w_rdy2;
  assign w_ld1  = in_valid && w_rdy1;
  assign w_ld2  = r_v1 && w_rdy2;
  assign w_ld3  = r_v2 && w_rdy3;

  assign in_ready  = w_rdy1;
  assign out_valid = r_v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_rdy1) r_v1 <= in_valid;
      if (w_rdy2) r_v2 <= r_v1;
      if (w_rdy3) r_v3 <= r_v2;
    end
  end

  // ------------------------------------------------------- S1: Booth rows
  logic [BITS:0]     w_bx;                 // {b, b[-1]=0}
  logic [C_RW-1:0]   w_row [C_ROWS];
  logic [C_ROWS-1:0] w_neg;
  logic [BITS:0]     w_a1;                 // +a, sign extended
  logic [BITS:0]     w_a2;                 // +2a

  assign w_bx = {b, 1'b0};
  assign w_a1 = {a[BITS-1], a};
  assign w_a2 = {a, 1'b0};

  generate
    for (genvar gi = 0; gi < C_ROWS; gi++) begin : g_booth
      logic [2:0]      w_trip;
      logic [C_RW-1:0] w_mag;
      logic            w_n;

      assign w_trip = w_bx[2*gi+2 -: 3];

      always_comb begin
        w_mag = '0;
        w_n   = 1'b0;
        case (w_trip)
          3'b001, 3'b010: w_mag = w_a1;
          3'b011:         w_mag = w_a2;
          3'b100: begin   w_mag = w_a2; w_n = 1'b1; end
          3'b101, 3'b110: begin w_mag = w_a1; w_n = 1'b1; end
          default: begin  w_mag = '0;   w_n = 1'b0; end
        endcase
      end

      // Negation is one's complement here; the +1 enters as a carry-in.
      assign w_row[gi] = w_n ? ~w_mag : w_mag;
      assign w_neg[gi] = w_n;
    end
  endgenerate

  logic [C_RW-1:0]   r_row1 [C_ROWS];
  logic [C_ROWS-1:0] r_neg1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_ROWS; i++) r_row1[i] <= '0;
      r_neg1 <= '0;
    end else if (w_ld1) begin
      for (int i = 0; i < C_ROWS; i++) r_row1[i] <= w_row[i];
      r_neg1 <= w_neg;
    end
  end

  // ------------------------------------------ S2: carry-save reduction
  // Start from the correction constant and the carry-in vector, then fold
  // each row in with a 3:2 compressor; carries past the top bit wrap away,
  // which is exactly modulo-2^(2*BITS) arithmetic.
  logic [C_PW-1:0] w_s, w_c, w_x, w_t, w_cin;

  always_comb begin
    w_cin = '0;
    w_x   = '0;
    w_t   = '0;
    for (int i = 0; i < C_ROWS; i++) w_cin[2*i] = r_neg1[i];
    w_s = C_CORR;
    w_c = w_cin;
    for (int i = 0; i < C_ROWS; i++) begin
      w_x = {{(C_PW-C_RW){1'b0}}, ~r_row1[i][BITS], r_row1[i][BITS-1:0]} << (2*i);
      w_t = w_s ^ w_c ^ w_x;
      w_c = ((w_s & w_c) | (w_s & w_x) | (w_c & w_x)) << 1;
      w_s = w_t;
    end
  end

  logic [C_PW-1:0] r_sum2, r_car2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum2 <= '0;
      r_car2 <= '0;
    end else if (w_ld2) begin
      r_sum2 <= w_s;
      r_car2 <= w_c;
    end
  end

  // ------------------------------------------- S3: carry-propagate sum
  logic signed [C_PW-1:0] w_prod;
  assign w_prod = r_sum2 + r_car2;

`ifdef BOOTH_MUL_PIPE_ACC_EN
  logic r_clr1, r_clr2;
  logic signed [OUT_W-1:0] r_acc;
  logic signed [OUT_W-1:0] w_prod_ext;

  assign w_prod_ext = OUT_W'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr1 <= 1'b0;
      r_clr2 <= 1'b0;
      r_acc  <= '0;
    end else begin
      if (w_ld1) r_clr1 <= acc_clear;
      if (w_ld2) r_clr2 <= r_clr1;
      if (w_ld3) r_acc  <= r_clr2 ? w_prod_ext : r_acc + w_prod_ext;
    end
  end

  assign out_data = r_acc;
`else
  logic [OUT_W-1:0] r_out;
  logic             w_unused_cfg;

  // acc_clear and ACC_BITS only matter for the accumulator build.
  assign w_unused_cfg = acc_clear ^ (ACC_BITS > 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out <= '0;
    else if (w_ld3) r_out <= w_prod;
  end

  assign out_data = r_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_booth_mul_pipe                                          |
// | Description : Self-checking bench for booth_mul_pipe. Runs a BITS=8 and  |
// |               a BITS=4 instance. A queue-based model predicts in_ready,  |
// |               out_valid and out_data every cycle; directed vectors pin   |
// |               hand-computed results. Honours BOOTH_MUL_PIPE_ACC_EN.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_booth_mul_pipe;

  localparam int LAT = 3;   // edges, counting the accept edge, until valid
`ifdef BOOTH_MUL_PIPE_ACC_EN
  localparam int W8 = 24;
  localparam int W4 = 16;
  localparam logic [W8-1:0] L_MIN_SQ = 24'h004000;
  localparam logic [W8-1:0] L_B2B_0  = 24'hFFC080;
  localparam logic [W8-1:0] L_B2B_1  = 24'hFFFFFF;
  localparam logic [W8-1:0] L_SEQ_0  = 24'h00000C;   // 12
  localparam logic [W8-1:0] L_SEQ_1  = 24'hFFFFEE;   // -18
  localparam logic [W8-1:0] L_SEQ_2  = 24'h003FEE;   // 16366
`else
  localparam int W8 = 16;
  localparam int W4 = 8;
  localparam logic [W8-1:0] L_MIN_SQ = 16'h4000;
  localparam logic [W8-1:0] L_B2B_0  = 16'hC080;
  localparam logic [W8-1:0] L_B2B_1  = 16'hFFFF;
  localparam logic [W8-1:0] L_SEQ_0  = 16'h000C;     // 12
  localparam logic [W8-1:0] L_SEQ_1  = 16'hFFE2;     // -30
  localparam logic [W8-1:0] L_SEQ_2  = 16'h4000;     // 16384
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid8 = 1'b0, acc_clear8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]    a8 = '0, b8 = '0;
  logic          in_ready8, out_valid8;
  logic [W8-1:0] out_data8;

  logic          in_valid4 = 1'b0, acc_clear4 = 1'b0, out_ready4 = 1'b1;
  logic [3:0]    a4 = '0, b4 = '0;
  logic          in_ready4, out_valid4;
  logic [W4-1:0] out_data4;

  booth_mul_pipe #(.BITS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .acc_clear(acc_clear8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8));

  booth_mul_pipe #(.BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .acc_clear(acc_clear4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4));

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed product, optionally folded into a running sum.
  // Truncation to the output width on storage supplies the modulo wrap.
  function automatic logic [63:0] model(input int av, input int bv, input bit clr,
                                        inout longint acc);
    longint p;
    p = longint'(av) * longint'(bv);
`ifdef BOOTH_MUL_PIPE_ACC_EN
    if (clr) acc = p;
    else     acc = acc + p;
    return acc;
`else
    return p;
`endif
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------- scoreboards
  logic [W8-1:0] exp_q8[$];
  int            acyc_q8[$];
  longint        acc_m8 = 0;
  logic [W8-1:0] got_q8[$];
  int            gotcyc_q8[$];
  int            acclog_q8[$];
  bit            saw_block8 = 1'b0;

  logic [W4-1:0] exp_q4[$];
  int            acyc_q4[$];
  longint        acc_m4 = 0;
  int            got_n4 = 0;

  // The oldest item never waits behind anything, so it reaches the output
  // register LAT edges after its accept regardless of backpressure. Three
  // stages mean the input only blocks with three items held and no drain.
  always @(negedge clk) begin : mon8
    bit expv, exprdy;
    if (!rst_n) begin
      exp_q8.delete(); acyc_q8.delete(); acc_m8 = 0;
      check("rst_out_valid8", 64'(out_valid8), 64'd0);
      check("rst_out_data8",  64'(out_data8),  64'd0);
      check("rst_in_ready8",  64'(in_ready8),  64'd1);
    end else begin
      exprdy = (exp_q8.size() < 3) || out_ready8;
      expv   = (exp_q8.size() > 0) && (cyc - acyc_q8[0] + 1 >= LAT);
      check("in_ready8",  64'(in_ready8),  64'(exprdy));
      check("out_valid8", 64'(out_valid8), 64'(expv));
      if (expv) check("out_data8", 64'(out_data8), 64'(exp_q8[0]));
      if (!in_ready8) saw_block8 = 1'b1;
      if (expv && out_ready8) begin
        got_q8.push_back(out_data8);
        gotcyc_q8.push_back(cyc);
        void'(exp_q8.pop_front());
        void'(acyc_q8.pop_front());
      end
      if (in_valid8 && exprdy) begin
        exp_q8.push_back(W8'(model(int'($signed(a8)), int'($signed(b8)), acc_clear8, acc_m8)));
        acyc_q8.push_back(cyc + 1);
        acclog_q8.push_back(cyc + 1);
      end
    end
  end

  always @(negedge clk) begin : mon4
    bit expv, exprdy;
    if (!rst_n) begin
      exp_q4.delete(); acyc_q4.delete(); acc_m4 = 0;
      check("rst_out_valid4", 64'(out_valid4), 64'd0);
      check("rst_out_data4",  64'(out_data4),  64'd0);
    end else begin
      exprdy = (exp_q4.size() < 3) || out_ready4;
      expv   = (exp_q4.size() > 0) && (cyc - acyc_q4[0] + 1 >= LAT);
      check("in_ready4",  64'(in_ready4),  64'(exprdy));
      check("out_valid4", 64'(out_valid4), 64'(expv));
      if (expv) check("out_data4", 64'(out_data4), 64'(exp_q4[0]));
      if (expv && out_ready4) begin
        got_n4++;
        void'(exp_q4.pop_front());
        void'(acyc_q4.pop_front());
      end
      if (in_valid4 && exprdy) begin
        exp_q4.push_back(W4'(model(int'($signed(a4)), int'($signed(b4)), acc_clear4, acc_m4)));
        acyc_q4.push_back(cyc + 1);
      end
    end
  end

  // -------------------------------------------------------------- drivers
  // Inputs change 1 time unit after a rising edge; each send returns just
  // after the edge that accepted the pair, leaving in_valid high.
  task automatic send8(input int av, input int bv, input bit clr);
    bit took;
    int n;
    took = 1'b0; n = 0;
    in_valid8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; acc_clear8 = clr;
    while (!took) begin
      @(negedge clk); took = in_ready8;
      @(posedge clk); #1;
      n++;
      if (!took && n > 200) begin
        vectors++; miscompares++;
        $display("FAIL send8_timeout: got no accept, expected accept within 200 cycles");
        return;
      end
    end
  endtask

  task automatic send4(input int av, input int bv, input bit clr);
    bit took;
    int n;
    took = 1'b0; n = 0;
    in_valid4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; acc_clear4 = clr;
    while (!took) begin
      @(negedge clk); took = in_ready4;
      @(posedge clk); #1;
      n++;
      if (!took && n > 200) begin
        vectors++; miscompares++;
        $display("FAIL send4_timeout: got no accept, expected accept within 200 cycles");
        return;
      end
    end
  endtask

  task automatic drain8();
    int n;
    n = 0;
    in_valid8 = 1'b0;
    while (exp_q8.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    check("drain8_empty", 64'(exp_q8.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain4();
    int n;
    n = 0;
    in_valid4 = 1'b0;
    while (exp_q4.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    check("drain4_empty", 64'(exp_q4.size()), 64'd0);
  endtask

  task automatic clear_logs();
    got_q8.delete(); gotcyc_q8.delete(); acclog_q8.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Most negative squared, latency pinned.
    clear_logs();
    send8(-128, -128, 1'b1);
    drain8();
    check("min_sq_value", 64'((got_q8.size() > 0) ? got_q8[0] : 'x), 64'(L_MIN_SQ));
    check("min_sq_latency",
          64'((got_q8.size() > 0 && acclog_q8.size() > 0) ? gotcyc_q8[0] - acclog_q8[0] + 1 : -1),
          64'(LAT));

    // Back-to-back pair delivered on consecutive cycles.
    clear_logs();
    send8(127, -128, 1'b1);
    send8(-1, 1, 1'b1);
    drain8();
    check("b2b_first",  64'((got_q8.size() > 0) ? got_q8[0] : 'x), 64'(L_B2B_0));
    check("b2b_second", 64'((got_q8.size() > 1) ? got_q8[1] : 'x), 64'(L_B2B_1));
    check("b2b_consecutive", 64'((got_q8.size() > 1) ? gotcyc_q8[1] - gotcyc_q8[0] : -1), 64'd1);

    // Short sequence: products, or running sum with clear on the first pair.
    clear_logs();
    send8(3, 4, 1'b1);
    send8(5, -6, 1'b0);
    send8(-128, -128, 1'b0);
    drain8();
    check("seq_0", 64'((got_q8.size() > 0) ? got_q8[0] : 'x), 64'(L_SEQ_0));
    check("seq_1", 64'((got_q8.size() > 1) ? got_q8[1] : 'x), 64'(L_SEQ_1));
    check("seq_2", 64'((got_q8.size() > 2) ? got_q8[2] : 'x), 64'(L_SEQ_2));

    // 16 random pairs with a 5-cycle output stall mid-stream.
    clear_logs();
    saw_block8 = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), i == 0);
        in_valid8 = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready8 = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready8 = 1'b1;
      end
    join
    drain8();
    check("stall_blocked", 64'(saw_block8), 64'd1);
    check("stall_count", 64'(got_q8.size()), 64'd16);

    // out_ready toggling every cycle while streaming.
    clear_logs();
    fork
      begin
        for (int i = 0; i < 12; i++) send8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), i == 0);
        in_valid8 = 1'b0;
      end
      begin
        repeat (40) begin @(posedge clk); #1 out_ready8 = ~out_ready8; end
        out_ready8 = 1'b1;
      end
    join
    out_ready8 = 1'b1;
    drain8();
    check("toggle_count", 64'(got_q8.size()), 64'd12);

    // Reset with two results in flight.
    out_ready8 = 1'b0;
    send8(11, -3, 1'b1);
    send8(-7, 9, 1'b0);
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin @(posedge clk); #1; n++; end
    check("rst_pre_valid", 64'(out_valid8), 64'd1);
    rst_n = 1'b0;
    in_valid8 = 1'b1;
    #1;
    check("rst_async_valid", 64'(out_valid8), 64'd0);
    check("rst_async_data",  64'(out_data8),  64'd0);
    check("rst_async_ready", 64'(in_ready8),  64'd1);
    repeat (3) @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    clear_logs();
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_stale", 64'(got_q8.size()), 64'd0);

    // Exhaustive 4-bit sweep.
    got_n4 = 0;
    for (int x = -8; x < 8; x++)
      for (int y = -8; y < 8; y++)
        send4(x, y, 1'b1);
    drain4();
    check("sweep4_count", 64'(got_n4), 64'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
